ps2_action_decoder: RTL and testbench

PS2_ACTION_DECODER -- requirements
Module: ps2_action_decoder

---
 rtl/ps2_pkg.sv | 68 ++++++
 rtl/ps2_action_decoder_if.sv | 22 ++
 rtl/action_fifo.sv | 80 ++++++++
 rtl/ps2_action_decoder.sv | 245 ++++++++++++++++++++++++
 tb/tb_ps2_action_decoder.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 action decoder: scan codes, action-code
// field layout, frame FSM states and the scan-code to action lookup.
package ps2_pkg;

    // Scan codes (set 2) recognised by the decoder
    localparam logic [7:0] SC_P0_A1  = 8'h1C;
    localparam logic [7:0] SC_P0_A2  = 8'h23;
    localparam logic [7:0] SC_P0_A3  = 8'h29;
    localparam logic [7:0] SC_P1_A1  = 8'h05;
    localparam logic [7:0] SC_P1_A2  = 8'h04;
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXTEND = 8'hE0;

    // Action code layout: [3] release, [2] player, [1:0] action number
    localparam int ACT_W          = 4;
    localparam int ACT_REL_BIT    = 3;
    localparam int ACT_PLAYER_BIT = 2;
    localparam int ACT_CODE_MSB   = 1;
    localparam int ACT_CODE_LSB   = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_state_e;

    typedef struct packed {
        logic             hit;
        logic [ACT_W-1:0] code;
    } map_result_t;

    // Translate a scan code into an action; hit=0 for unmapped codes
    function automatic map_result_t map_scan_code(input logic [7:0] sc, input logic rel);
        map_result_t r;
        r.hit               = 1'b1;
        r.code              = '0;
        r.code[ACT_REL_BIT] = rel;
        case (sc)
            SC_P0_A1: begin
                r.code[ACT_PLAYER_BIT]              = 1'b0;
                r.code[ACT_CODE_MSB:ACT_CODE_LSB]   = 2'd1;
            end
            SC_P0_A2: begin
                r.code[ACT_PLAYER_BIT]              = 1'b0;
                r.code[ACT_CODE_MSB:ACT_CODE_LSB]   = 2'd2;
            end
            SC_P0_A3: begin
                r.code[ACT_PLAYER_BIT]              = 1'b0;
                r.code[ACT_CODE_MSB:ACT_CODE_LSB]   = 2'd3;
            end
            SC_P1_A1: begin
                r.code[ACT_PLAYER_BIT]              = 1'b1;
                r.code[ACT_CODE_MSB:ACT_CODE_LSB]   = 2'd1;
            end
            SC_P1_A2: begin
                r.code[ACT_PLAYER_BIT]              = 1'b1;
                r.code[ACT_CODE_MSB:ACT_CODE_LSB]   = 2'd2;
            end
            default: begin
                r.hit  = 1'b0;
                r.code = '0;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_action_decoder_if.sv
// Action output stream: producer presents out_data/out_valid, consumer
// answers with out_ready.
interface ps2_action_decoder_if;
    import ps2_pkg::*;

    logic [ACT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/action_fifo.sv
// Small synchronous FIFO for 4-bit action codes with flush.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module action_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push_valid,
    input  logic [ACT_W-1:0] push_data,
    output logic [ACT_W-1:0] pop_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ACT_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign pop_valid = !empty;
    assign pop_data  = mem_q[rd_ptr_q];
    assign do_pop    = pop_valid && pop_ready;
    assign do_push   = push_valid && (!full || do_pop);

    // Pointer and occupancy bookkeeping; flush wins over everything
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + (AW+1)'(1);
            end else if (!do_push && do_pop) begin
                count_d = count_q - (AW+1)'(1);
            end
        end
    end

    // Pointer/count registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, no reset so it maps onto RAM primitives
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/ps2_action_decoder.sv
// PS/2 keyboard receiver that turns game-key scan codes into queued
// player actions. Raw PS/2 lines are synchronised, ps2_clk is glitch
// filtered, frames are checked for start/parity/stop and a stall timeout.
module ps2_action_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN   = 8,
    parameter int TIMEOUT_CYC  = 50000,
    parameter int FIFO_DEPTH   = 8,
    parameter int EMIT_RELEASE = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ps2_clk,
    input  logic                        ps2_data,
    input  logic                        round_start,
    ps2_action_decoder_if.master        act,
    output logic                        frame_err,
    output logic                        timeout_err,
    output logic                        overflow
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    // Synchroniser flops (idle-high lines)
    logic clk_meta_q, clk_sync_q;
    logic data_meta_q, data_sync_q;

    // Glitch filter
    logic          filt_level_q, filt_level_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          fall_edge;

    // Frame receiver
    frame_state_e  state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          byte_valid_q, byte_valid_d;
    logic [7:0]    byte_q, byte_d;
    logic          frame_err_q, frame_err_d;
    logic          timeout_err_q, timeout_err_d;

    // Decode stage
    logic             break_q, break_d;
    logic             ext_q, ext_d;
    logic             round_q, round_d;
    logic             overflow_q, overflow_d;
    logic             flush;
    logic             push_valid;
    logic [ACT_W-1:0] push_code;
    map_result_t      lookup;

    // FIFO connections
    logic [ACT_W-1:0] fifo_data;
    logic             fifo_valid;
    logic             fifo_full;
    logic             fifo_empty;

    // Two-flop synchronisers for both PS/2 lines
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            clk_meta_q  <= ps2_clk;
            clk_sync_q  <= clk_meta_q;
            data_meta_q <= ps2_data;
            data_sync_q <= data_meta_q;
        end
    end

    // Accept a new ps2_clk level only after FILTER_LEN consecutive differing samples
    always_comb begin
        filt_level_d = filt_level_q;
        filt_cnt_d   = filt_cnt_q;
        fall_edge    = 1'b0;
        if (clk_sync_q == filt_level_q) begin
            filt_cnt_d = '0;
        end else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
            filt_level_d = clk_sync_q;
            filt_cnt_d   = '0;
            fall_edge    = filt_level_q;
        end else begin
            filt_cnt_d = filt_cnt_q + FW'(1);
        end
    end

    // Frame FSM: one step per filtered falling edge, stall timeout outside IDLE
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        parity_d      = parity_q;
        tmo_cnt_d     = tmo_cnt_q;
        byte_valid_d  = 1'b0;
        byte_d        = byte_q;
        frame_err_d   = 1'b0;
        timeout_err_d = 1'b0;
        if (fall_edge) begin
            tmo_cnt_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (!data_sync_q) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                ST_DATA: begin
                    shift_d   = {data_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    parity_d = data_sync_q;
                    state_d  = ST_STOP;
                end
                ST_STOP: begin
                    if ((^{shift_q, parity_q}) && data_sync_q) begin
                        byte_valid_d = 1'b1;
                        byte_d       = shift_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            if (tmo_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                state_d       = ST_IDLE;
                tmo_cnt_d     = '0;
                timeout_err_d = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TW'(1);
            end
        end else begin
            tmo_cnt_d = '0;
        end
    end

    // Filter and frame receiver registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_level_q  <= 1'b1;
            filt_cnt_q    <= '0;
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            parity_q      <= 1'b0;
            tmo_cnt_q     <= '0;
            byte_valid_q  <= 1'b0;
            byte_q        <= '0;
            frame_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            filt_level_q  <= filt_level_d;
            filt_cnt_q    <= filt_cnt_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            parity_q      <= parity_d;
            tmo_cnt_q     <= tmo_cnt_d;
            byte_valid_q  <= byte_valid_d;
            byte_q        <= byte_d;
            frame_err_q   <= frame_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign lookup = map_scan_code(byte_q, break_q);

    // Prefix tracking, action lookup, push gating and round-end flush
    always_comb begin
        break_d    = break_q;
        ext_d      = ext_q;
        round_d    = round_start;
        push_valid = 1'b0;
        push_code  = lookup.code;
        flush      = round_q && !round_start;
        overflow_d = 1'b0;
        if (byte_valid_q) begin
            if (byte_q == SC_BREAK) begin
                break_d = 1'b1;
            end else if (byte_q == SC_EXTEND) begin
                ext_d = 1'b1;
            end else begin
                break_d = 1'b0;
                ext_d   = 1'b0;
                if (lookup.hit && !ext_q && (!break_q || (EMIT_RELEASE != 0)) && round_start) begin
                    push_valid = 1'b1;
                end
            end
        end
        if (push_valid && fifo_full && !(fifo_valid && act.out_ready)) begin
            overflow_d = 1'b1;
        end
    end

    // Decode stage registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            break_q    <= 1'b0;
            ext_q      <= 1'b0;
            round_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            break_q    <= break_d;
            ext_q      <= ext_d;
            round_q    <= round_d;
            overflow_q <= overflow_d;
        end
    end

    action_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push_valid (push_valid),
        .push_data  (push_code),
        .pop_data   (fifo_data),
        .pop_valid  (fifo_valid),
        .pop_ready  (act.out_ready),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // Empty FIFO presents zero so the head never shows stale RAM contents
    assign act.out_data  = fifo_empty ? '0 : fifo_data;
    assign act.out_valid = fifo_valid;
    assign frame_err     = frame_err_q;
    assign timeout_err   = timeout_err_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_ps2_action_decoder.sv
// Directed bench for ps2_action_decoder: two instances share the PS/2 lines,
// one queuing releases and one dropping them.
module tb_ps2_action_decoder;

    localparam int FILTER_LEN  = 4;
    localparam int TIMEOUT_CYC = 300;
    localparam int FIFO_DEPTH  = 4;
    localparam int HALF        = 12;

    logic clk = 1'b0;
    logic rst;
    logic ps2_clk;
    logic ps2_data;
    logic round_start;
    logic out_ready;

    logic frame_err, timeout_err, overflow;
    logic frame_err0, timeout_err0, overflow0;

    int n_assert = 0;
    int n_fail   = 0;
    int fe_cnt   = 0, to_cnt  = 0, ov_cnt  = 0;
    int fe0_cnt  = 0, to0_cnt = 0, ov0_cnt = 0;
    int fe_base, to_base, ov_base;

    ps2_action_decoder_if act_if ();
    ps2_action_decoder_if act0_if ();

    assign act_if.out_ready  = out_ready;
    assign act0_if.out_ready = out_ready;

    ps2_action_decoder #(
        .FILTER_LEN   (FILTER_LEN),
        .TIMEOUT_CYC  (TIMEOUT_CYC),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .EMIT_RELEASE (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .round_start (round_start),
        .act         (act_if),
        .frame_err   (frame_err),
        .timeout_err (timeout_err),
        .overflow    (overflow)
    );

    ps2_action_decoder #(
        .FILTER_LEN   (FILTER_LEN),
        .TIMEOUT_CYC  (TIMEOUT_CYC),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .EMIT_RELEASE (0)
    ) dut0 (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .round_start (round_start),
        .act         (act0_if),
        .frame_err   (frame_err0),
        .timeout_err (timeout_err0),
        .overflow    (overflow0)
    );

    always #5 clk = ~clk;

    // Count high cycles of each pulse output
    always @(negedge clk) begin
        if (frame_err === 1'b1)    fe_cnt++;
        if (timeout_err === 1'b1)  to_cnt++;
        if (overflow === 1'b1)     ov_cnt++;
        if (frame_err0 === 1'b1)   fe0_cnt++;
        if (timeout_err0 === 1'b1) to0_cnt++;
        if (overflow0 === 1'b1)    ov0_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // {stop, parity, data[7:0], start}; correct parity makes data+parity odd
    function automatic logic [10:0] build(input logic [7:0] b, input logic bad_par, input logic stop);
        return {stop, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ps2_data = f[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        repeat (HALF) @(negedge clk);
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [10:0] f);
        send_bits(f, 11);
        repeat (20) @(negedge clk);
    endtask

    task automatic pop_one();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic snap();
        fe_base = fe_cnt;
        to_base = to_cnt;
        ov_base = ov_cnt;
    endtask

    logic [3:0] exp_q [4];

    initial begin
        rst         = 1'b1;
        ps2_clk     = 1'b1;
        ps2_data    = 1'b1;
        round_start = 1'b0;
        out_ready   = 1'b0;
        repeat (5) @(negedge clk);

        // Reset state
        check("rst_valid", act_if.out_valid, 1'b0);
        check("rst_data", act_if.out_data, 4'h0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_timeout_err", timeout_err, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        round_start = 1'b1;
        repeat (5) @(negedge clk);
        $display("step reset done");

        // Valid 0x1C -> P0 action 1
        snap();
        send_frame(build(8'h1C, 1'b0, 1'b1));
        check("1c_valid", act_if.out_valid, 1'b1);
        check("1c_data", act_if.out_data, 4'b0001);
        check("1c_data_norel", act0_if.out_data, 4'b0001);
        check("1c_fe", fe_cnt - fe_base, 0);
        check("1c_to", to_cnt - to_base, 0);
        pop_one();
        check("1c_single", act_if.out_valid, 1'b0);
        $display("step frame 0x1C");

        // Break prefix then 0x23: release queued only with EMIT_RELEASE=1
        send_frame(build(8'hF0, 1'b0, 1'b1));
        check("f0_nothing", act_if.out_valid, 1'b0);
        send_frame(build(8'h23, 1'b0, 1'b1));
        check("rel_valid", act_if.out_valid, 1'b1);
        check("rel_data", act_if.out_data, 4'b1010);
        check("rel_dropped", act0_if.out_valid, 1'b0);
        pop_one();
        check("rel_popped", act_if.out_valid, 1'b0);
        $display("step release F0 23");

        // Bad parity on 0x05
        snap();
        send_frame(build(8'h05, 1'b1, 1'b1));
        check("par_fe", fe_cnt - fe_base, 1);
        check("par_empty", act_if.out_valid, 1'b0);
        $display("step bad parity");

        // Bad stop bit on 0x1C
        snap();
        send_frame(build(8'h1C, 1'b0, 1'b0));
        check("stop_fe", fe_cnt - fe_base, 1);
        check("stop_empty", act_if.out_valid, 1'b0);
        $display("step bad stop");

        // Stall after start + 4 data bits, then a clean 0x04
        snap();
        send_bits(build(8'h04, 1'b0, 1'b1), 5);
        repeat (TIMEOUT_CYC + 20) @(negedge clk);
        check("tmo_pulse", to_cnt - to_base, 1);
        check("tmo_no_fe", fe_cnt - fe_base, 0);
        send_frame(build(8'h04, 1'b0, 1'b1));
        check("tmo_next_valid", act_if.out_valid, 1'b1);
        check("tmo_next_data", act_if.out_data, 4'b0110);
        pop_one();
        $display("step timeout");

        // Short glitches on ps2_clk with data low must not start a frame
        snap();
        @(negedge clk);
        ps2_data = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b0;
        @(negedge clk);
        ps2_clk = 1'b1;
        repeat (6) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (FILTER_LEN - 1) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (6) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (2) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (6) @(negedge clk);
        ps2_data = 1'b1;
        send_frame(build(8'h1C, 1'b0, 1'b1));
        check("glitch_valid", act_if.out_valid, 1'b1);
        check("glitch_data", act_if.out_data, 4'b0001);
        check("glitch_fe", fe_cnt - fe_base, 0);
        pop_one();
        repeat (TIMEOUT_CYC + 20) @(negedge clk);
        check("glitch_to", to_cnt - to_base, 0);
        $display("step glitch filter");

        // round_start low: 0x29 dropped, no overflow
        snap();
        round_start = 1'b0;
        send_frame(build(8'h29, 1'b0, 1'b1));
        check("round_off_empty", act_if.out_valid, 1'b0);
        check("round_off_ov", ov_cnt - ov_base, 0);
        round_start = 1'b1;
        repeat (3) @(negedge clk);
        $display("step round inactive");

        // Falling round_start flushes a queued action
        send_frame(build(8'h23, 1'b0, 1'b1));
        check("flush_pre", act_if.out_valid, 1'b1);
        round_start = 1'b0;
        repeat (2) @(negedge clk);
        check("flush_post", act_if.out_valid, 1'b0);
        check("flush_data", act_if.out_data, 4'h0);
        round_start = 1'b1;
        repeat (3) @(negedge clk);
        $display("step flush");

        // FIFO_DEPTH+1 frames without draining
        snap();
        exp_q[0] = 4'b0001;
        exp_q[1] = 4'b0010;
        exp_q[2] = 4'b0011;
        exp_q[3] = 4'b0101;
        send_frame(build(8'h1C, 1'b0, 1'b1));
        send_frame(build(8'h23, 1'b0, 1'b1));
        send_frame(build(8'h29, 1'b0, 1'b1));
        send_frame(build(8'h05, 1'b0, 1'b1));
        send_frame(build(8'h04, 1'b0, 1'b1));
        check("ovf_pulse", ov_cnt - ov_base, 1);
        repeat (5) @(negedge clk);
        check("ovf_head_stable", act_if.out_data, exp_q[0]);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            check($sformatf("drain_valid_%0d", i), act_if.out_valid, 1'b1);
            check($sformatf("drain_data_%0d", i), act_if.out_data, exp_q[i]);
            pop_one();
        end
        check("drain_empty", act_if.out_valid, 1'b0);
        $display("step overflow and drain");

        // Reset in the middle of a frame, then a clean 0x23
        send_bits(build(8'h29, 1'b0, 1'b1), 5);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_valid", act_if.out_valid, 1'b0);
        check("midrst_fe", frame_err, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        snap();
        send_frame(build(8'h23, 1'b0, 1'b1));
        check("midrst_next_valid", act_if.out_valid, 1'b1);
        check("midrst_next_data", act_if.out_data, 4'b0010);
        check("midrst_next_fe", fe_cnt - fe_base, 0);
        pop_one();
        repeat (TIMEOUT_CYC + 20) @(negedge clk);
        check("midrst_no_to", to_cnt - to_base, 0);
        $display("step mid-frame reset");

        // Both variants see identical framing and overflow events
        check("inst_fe_match", fe0_cnt, fe_cnt);
        check("inst_to_match", to0_cnt, to_cnt);
        check("inst_ov_match", ov0_cnt, ov_cnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
